// File: rtl/connect4_pkg.sv
// Shared Connect-4 board constants, payload types and the drop-controller
// state encoding.
package connect4_pkg;

  localparam int unsigned NUM_COLS    = 7;
  localparam int unsigned NUM_ROWS    = 6;
  localparam int unsigned BOARD_CELLS = NUM_COLS * NUM_ROWS;
  localparam int unsigned COL_W       = 3;
  localparam int unsigned CNT_W       = 6;

  typedef logic [COL_W-1:0]    col_t;
  typedef logic [NUM_ROWS-1:0] onoff_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    PLACE  = 3'd2,
    EMIT   = 3'd3,
    REJECT = 3'd4
  } drop_state_t;

endpackage

// File: rtl/piece_drop_ctrl.sv
// piece_drop_ctrl: owns per-column thermometer occupancy of the 7x6 board,
// accepts drop requests, rejects full/out-of-range columns and emits a
// one-cycle drop_valid with the column's new onoff word for the VGA row decode.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   drop_req, drop_col  drop request and target column (sampled in IDLE only)
//   drop_ready          high while idle and able to accept a request
//   drop_valid          one-cycle pulse, piece placed (onoff_val/vga_col/piece_player valid)
//   drop_reject         one-cycle pulse, request refused
//   onoff_val, vga_col, piece_player  last placed column data (held)
//   cur_player          player to move (0 = P1, 1 = P2)
//   board_full          all cells occupied
//   undo_req, undo_valid  only with PIECE_DROP_UNDO_EN: one-deep undo of last drop
//
// Optional feature macro: PIECE_DROP_UNDO_EN
module piece_drop_ctrl
  import connect4_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                drop_req,
  input  logic [COL_W-1:0]    drop_col,
  output logic                drop_ready,
  output logic                drop_valid,
  output logic                drop_reject,
  output logic [NUM_ROWS-1:0] onoff_val,
  output logic [COL_W-1:0]    vga_col,
  output logic                piece_player,
  output logic                cur_player,
  output logic                board_full
`ifdef PIECE_DROP_UNDO_EN
  ,
  input  logic                undo_req,
  output logic                undo_valid
`endif
);

  drop_state_t state_q, state_d;
  col_t        col_q, col_d;
  onoff_t      occ_q [NUM_COLS];
  onoff_t      occ_d [NUM_COLS];
  cnt_t        count_q, count_d;
  logic        cur_player_q, cur_player_d;
  logic        drop_ready_q, drop_ready_d;
  logic        drop_valid_q, drop_valid_d;
  logic        drop_reject_q, drop_reject_d;
  onoff_t      onoff_val_q, onoff_val_d;
  col_t        vga_col_q, vga_col_d;
  logic        piece_player_q, piece_player_d;
  logic        board_full_q, board_full_d;

  onoff_t      sel_occ;
  logic        col_ok;

`ifdef PIECE_DROP_UNDO_EN
  logic        hist_valid_q, hist_valid_d;
  col_t        hist_col_q, hist_col_d;
  logic        undo_valid_q, undo_valid_d;
  onoff_t      hist_occ;
`endif

  // Occupancy word of the latched column (zero when the column is out of range).
  always_comb begin
    sel_occ = '0;
    col_ok  = 1'b0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (col_q == COL_W'(i)) begin
        sel_occ = occ_q[i];
        col_ok  = 1'b1;
      end
    end
  end

`ifdef PIECE_DROP_UNDO_EN
  // Occupancy word of the column recorded in the undo history.
  always_comb begin
    hist_occ = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (hist_col_q == COL_W'(i)) hist_occ = occ_q[i];
    end
  end
`endif

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    occ_d          = occ_q;
    count_d        = count_q;
    cur_player_d   = cur_player_q;
    drop_valid_d   = 1'b0;
    drop_reject_d  = 1'b0;
    onoff_val_d    = onoff_val_q;
    vga_col_d      = vga_col_q;
    piece_player_d = piece_player_q;
`ifdef PIECE_DROP_UNDO_EN
    hist_valid_d   = hist_valid_q;
    hist_col_d     = hist_col_q;
    undo_valid_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (drop_req) begin
          col_d   = drop_col;
          state_d = CHECK;
        end
`ifdef PIECE_DROP_UNDO_EN
        else if (undo_req && hist_valid_q) begin
          // Undo completes in place: the board shrinks and undo_valid pulses next cycle.
          for (int i = 0; i < NUM_COLS; i++) begin
            if (hist_col_q == COL_W'(i)) occ_d[i] = occ_q[i] >> 1;
          end
          onoff_val_d  = hist_occ >> 1;
          vga_col_d    = hist_col_q;
          count_d      = count_q - CNT_W'(1);
          cur_player_d = ~cur_player_q;
          undo_valid_d = 1'b1;
          hist_valid_d = 1'b0;
        end
`endif
      end
      CHECK: begin
        if (!col_ok || sel_occ[NUM_ROWS-1] || board_full_q) state_d = REJECT;
        else                                                state_d = PLACE;
      end
      PLACE: begin
        for (int i = 0; i < NUM_COLS; i++) begin
          if (col_q == COL_W'(i)) occ_d[i] = {occ_q[i][NUM_ROWS-2:0], 1'b1};
        end
        if (count_q < CNT_W'(BOARD_CELLS)) count_d = count_q + CNT_W'(1);
        // Output payload is registered here so it is live during EMIT.
        drop_valid_d   = 1'b1;
        onoff_val_d    = {sel_occ[NUM_ROWS-2:0], 1'b1};
        vga_col_d      = col_q;
        piece_player_d = cur_player_q;
`ifdef PIECE_DROP_UNDO_EN
        hist_valid_d   = 1'b1;
        hist_col_d     = col_q;
`endif
        state_d        = EMIT;
      end
      EMIT: begin
        cur_player_d = ~cur_player_q;
        state_d      = IDLE;
      end
      REJECT: begin
        // Pulse lands one cycle later so both outcomes share the same latency.
        drop_reject_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    drop_ready_d = (state_d == IDLE);
    board_full_d = (count_d == CNT_W'(BOARD_CELLS));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      col_q          <= '0;
      for (int i = 0; i < NUM_COLS; i++) occ_q[i] <= '0;
      count_q        <= '0;
      cur_player_q   <= 1'b0;
      drop_ready_q   <= 1'b1;
      drop_valid_q   <= 1'b0;
      drop_reject_q  <= 1'b0;
      onoff_val_q    <= '0;
      vga_col_q      <= '0;
      piece_player_q <= 1'b0;
      board_full_q   <= 1'b0;
`ifdef PIECE_DROP_UNDO_EN
      hist_valid_q   <= 1'b0;
      hist_col_q     <= '0;
      undo_valid_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      occ_q          <= occ_d;
      count_q        <= count_d;
      cur_player_q   <= cur_player_d;
      drop_ready_q   <= drop_ready_d;
      drop_valid_q   <= drop_valid_d;
      drop_reject_q  <= drop_reject_d;
      onoff_val_q    <= onoff_val_d;
      vga_col_q      <= vga_col_d;
      piece_player_q <= piece_player_d;
      board_full_q   <= board_full_d;
`ifdef PIECE_DROP_UNDO_EN
      hist_valid_q   <= hist_valid_d;
      hist_col_q     <= hist_col_d;
      undo_valid_q   <= undo_valid_d;
`endif
    end
  end

  assign drop_ready   = drop_ready_q;
  assign drop_valid   = drop_valid_q;
  assign drop_reject  = drop_reject_q;
  assign onoff_val    = onoff_val_q;
  assign vga_col      = vga_col_q;
  assign piece_player = piece_player_q;
  assign cur_player   = cur_player_q;
  assign board_full   = board_full_q;
`ifdef PIECE_DROP_UNDO_EN
  assign undo_valid   = undo_valid_q;
`endif

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// Self-checking bench for piece_drop_ctrl against a column-height game model.
module tb_piece_drop_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       drop_req;
  logic [2:0] drop_col;
  logic       drop_ready, drop_valid, drop_reject;
  logic [5:0] onoff_val;
  logic [2:0] vga_col;
  logic       piece_player, cur_player, board_full;
`ifdef PIECE_DROP_UNDO_EN
  logic       undo_req;
  logic       undo_valid;
`endif

  int checks = 0;
  int errors = 0;

  // Game model: column heights, whose turn, total pieces, last emitted payload.
  int         heights [7];
  bit         m_player;
  int         m_count;
  logic [5:0] m_onoff;
  logic [2:0] m_vga;
  bit         m_pp;
`ifdef PIECE_DROP_UNDO_EN
  bit         m_hist_valid;
  int         m_hist_col;
`endif

  always #5 clk = ~clk;

  piece_drop_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .drop_req     (drop_req),
    .drop_col     (drop_col),
    .drop_ready   (drop_ready),
    .drop_valid   (drop_valid),
    .drop_reject  (drop_reject),
    .onoff_val    (onoff_val),
    .vga_col      (vga_col),
    .piece_player (piece_player),
    .cur_player   (cur_player),
    .board_full   (board_full)
`ifdef PIECE_DROP_UNDO_EN
    ,
    .undo_req     (undo_req),
    .undo_valid   (undo_valid)
`endif
  );

  task automatic model_reset();
    for (int i = 0; i < 7; i++) heights[i] = 0;
    m_player = 0; m_count = 0; m_onoff = '0; m_vga = '0; m_pp = 0;
`ifdef PIECE_DROP_UNDO_EN
    m_hist_valid = 0; m_hist_col = 0;
`endif
  endtask

  // Game rule: a drop succeeds into an in-range column that has room.
  task automatic model_drop(input int col, output bit ok);
    ok = (col < 7) && (heights[col] < 6) && (m_count < 42);
    if (ok) begin
      heights[col]++;
      m_count++;
      m_onoff  = 6'((1 << heights[col]) - 1);
      m_vga    = 3'(col);
      m_pp     = m_player;
      m_player = ~m_player;
`ifdef PIECE_DROP_UNDO_EN
      m_hist_valid = 1; m_hist_col = col;
`endif
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; drop_req = 1'b0; drop_col = '0;
`ifdef PIECE_DROP_UNDO_EN
    undo_req = 1'b0;
`endif
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Issue one request from a negedge; ends four negedges later with the DUT idle.
  // v/r are sampled in the third cycle after acceptance, t_ok flags stray pulses.
  task automatic drop_op(input logic [2:0] col, output bit v, output bit r, output bit t_ok);
    t_ok = drop_ready;
    drop_req = 1'b1; drop_col = col;
    @(posedge clk);
    @(negedge clk);
    drop_req = 1'b0; drop_col = 3'($urandom_range(0, 7));
    if (drop_valid || drop_reject) t_ok = 0;
    @(negedge clk);
    if (drop_valid || drop_reject) t_ok = 0;
    @(negedge clk);
    v = drop_valid; r = drop_reject;
    @(negedge clk);
    if (drop_valid || drop_reject) t_ok = 0;
  endtask

  // Drop into one column and compare the whole observable outcome with the model.
  task automatic run_drop(input string name, input int col);
    bit v, r, t_ok, ok;
    logic [14:0] obs, exp;
    drop_op(3'(col), v, r, t_ok);
    model_drop(col, ok);
    obs = {v, r, onoff_val, vga_col, piece_player, cur_player, board_full};
    exp = {ok, !ok, m_onoff, m_vga, m_pp, m_player, (m_count == 42)};
    checks++;
    if (obs !== exp || !t_ok) begin
      errors++;
      $display("FAIL %s col=%0d: got {v,r,onoff,col,pp,cur,full}=%b timing_ok=%0d, expected %b", name, col, obs, t_ok, exp);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({drop_ready, drop_valid, drop_reject, onoff_val, vga_col, piece_player, cur_player, board_full}
        !== {1'b1, 1'b0, 1'b0, 6'b0, 3'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b rej=%b onoff=%b col=%0d pp=%b cur=%b full=%b, expected 1,0,0,000000,0,0,0,0",
               drop_ready, drop_valid, drop_reject, onoff_val, vga_col, piece_player, cur_player, board_full);
    end
  endtask

  task automatic test_first_drop();
    apply_reset();
    run_drop("first_drop", 3);
    checks++;
    if (onoff_val !== 6'b000001 || cur_player !== 1'b1) begin
      errors++;
      $display("FAIL first_drop_vals: got onoff=%b cur=%b, expected 000001 1", onoff_val, cur_player);
    end
  endtask

  task automatic test_column_fill();
    apply_reset();
    for (int k = 0; k < 7; k++) run_drop("column_fill", 0);
  endtask

  task automatic test_out_of_range();
    run_drop("out_of_range", 7);
    run_drop("after_oor", 1);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    run_drop("pre_mid_reset", 5);
    drop_req = 1'b1; drop_col = 3'd5;
    @(posedge clk);
    @(negedge clk);
    drop_req = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (drop_valid !== 1'b0 || drop_reject !== 1'b0 || cur_player !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_pulse: got valid=%b rej=%b cur=%b, expected 0 0 0", drop_valid, drop_reject, cur_player);
      end
    end
    run_drop("after_mid_reset", 5);
  endtask

  // drop_req held high: one acceptance every 4 cycles, busy-time requests are dropped.
  task automatic test_back_to_back();
    int pulses = 0;
    bit ok;
    apply_reset();
    drop_req = 1'b1; drop_col = 3'd2;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (drop_valid) pulses++;
    end
    drop_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (drop_valid) pulses++;
    end
    for (int k = 0; k < 5; k++) model_drop(2, ok);
    checks++;
    if (pulses != 5 || onoff_val !== m_onoff || cur_player !== m_player) begin
      errors++;
      $display("FAIL back_to_back: got pulses=%0d onoff=%b cur=%b, expected 5 %b %b", pulses, onoff_val, cur_player, m_onoff, m_player);
    end
    run_drop("b2b_follow", 2);
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 40; k++) run_drop("random", int'($urandom_range(0, 7)));
  endtask

  task automatic test_board_full();
    apply_reset();
    for (int c = 0; c < 7; c++)
      for (int k = 0; k < 6; k++) begin
        if (c == 6 && k == 5) begin
          checks++;
          if (board_full !== 1'b0) begin
            errors++;
            $display("FAIL full_at_41: got %b, expected 0", board_full);
          end
        end
        run_drop("fill_board", c);
      end
    run_drop("full_reject", int'($urandom_range(0, 6)));
    apply_reset();
    checks++;
    if (board_full !== 1'b0 || cur_player !== 1'b0 || onoff_val !== 6'b0) begin
      errors++;
      $display("FAIL full_reset: got full=%b cur=%b onoff=%b, expected 0 0 000000", board_full, cur_player, onoff_val);
    end
    for (int c = 0; c < 7; c++) run_drop("post_full_reset", c);
  endtask

`ifdef PIECE_DROP_UNDO_EN
  task automatic test_undo();
    bit exp_uv;
    apply_reset();
    run_drop("undo_setup", 4);
    run_drop("undo_setup", 4);
    for (int u = 0; u < 2; u++) begin
      exp_uv = m_hist_valid;
      if (m_hist_valid) begin
        heights[m_hist_col]--; m_count--; m_player = ~m_player;
        m_onoff = 6'((1 << heights[m_hist_col]) - 1); m_vga = 3'(m_hist_col);
        m_hist_valid = 0;
      end
      undo_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      undo_req = 1'b0;
      checks++;
      if ({undo_valid, onoff_val, vga_col, cur_player} !== {exp_uv, m_onoff, m_vga, m_player}) begin
        errors++;
        $display("FAIL undo_%0d: got uv=%b onoff=%b col=%0d cur=%b, expected %b %b %0d %b",
                 u, undo_valid, onoff_val, vga_col, cur_player, exp_uv, m_onoff, m_vga, m_player);
      end
      @(negedge clk);
    end
    run_drop("after_undo", 4);
  endtask
`endif

  initial begin
    reset = 1'b1; drop_req = 1'b0; drop_col = '0;
`ifdef PIECE_DROP_UNDO_EN
    undo_req = 1'b0;
`endif
    model_reset();
    test_reset();
    test_first_drop();
    test_column_fill();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_board_full();
`ifdef PIECE_DROP_UNDO_EN
    test_undo();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
